// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO subsystem.
// Holds default geometry, watermark defaults, read-mode encodings and a clog2 helper.
package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 32;
  localparam int unsigned DEFAULT_DEPTH     = 16;
  localparam int unsigned DEFAULT_AE_THRESH = 2;

  // Read-mode encodings for the FWFT parameter
  localparam int unsigned FWFT_STD = 0;
  localparam int unsigned FWFT_ON  = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [clog2(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with watermarks, occupancy count, sticky errors
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = DEFAULT_AE_THRESH,
  parameter int unsigned FWFT      = FWFT_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [WIDTH-1:0]        wdata,
  input  logic                    r_en,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [clog2(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clr_err
);

  localparam int unsigned ADDR_W = clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
  end
  if (FWFT > FWFT_ON) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [WIDTH-1:0]  ram_rdata;
  logic              rd_acc;
  logic              wr_acc;

  // A full FIFO still accepts a write when a read frees a slot in the same cycle
  assign rd_acc = r_en & ~empty;
  assign wr_acc = w_en & (~full | rd_acc);

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en & ~wr_acc)  overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (r_en & empty)    underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));

  if (FWFT == FWFT_STD) begin : g_std
    logic [WIDTH-1:0] rdata_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q    <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rdata_q <= ram_rdata;
      end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_fwft
    // Head entry is presented directly; r_en only acknowledges it
    assign rdata    = ram_rdata;
    assign rd_valid = ~empty;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read and an FWFT instance
// share one stimulus stream; expected values are written out by hand.
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 16;
  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          w_en;
  logic          r_en;
  logic          clr_err;
  logic [W-1:0]  wdata;

  logic [W-1:0]  rdata0,    rdata1;
  logic          rd_valid0, rd_valid1;
  logic          full0,     full1;
  logic          empty0,    empty1;
  logic          af0,       af1;
  logic          ae0,       ae1;
  logic [CW-1:0] count0,    count1;
  logic          ovf0,      ovf1;
  logic          unf0,      unf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(FWFT_STD)
  ) dut_std (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .rdata(rdata0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
  );

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_THRESH(14), .AE_THRESH(2), .FWFT(FWFT_ON)
  ) dut_fwft (
    .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en),
    .rdata(rdata1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en    = 1'b0;
    r_en    = 1'b0;
    clr_err = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 64'(count0), 64'(0));
    check({tag, "_empty"}, 64'(empty0), 64'(1));
    check({tag, "_ae"},    64'(ae0),    64'(1));
    check({tag, "_full"},  64'(full0),  64'(0));
    check({tag, "_af"},    64'(af0),    64'(0));
    check({tag, "_rdv"},   64'(rd_valid0), 64'(0));
    check({tag, "_rdata"}, 64'(rdata0), 64'(0));
    check({tag, "_ovf"},   64'(ovf0),   64'(0));
    check({tag, "_unf"},   64'(unf0),   64'(0));
    check({tag, "_fwft_rdv"}, 64'(rd_valid1), 64'(0));
  endtask

  initial begin
    idle();
    wdata = '0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst");

    // Fill 1..16, watching the watermarks
    for (int i = 1; i <= 16; i++) begin
      w_en  = 1'b1;
      wdata = W'(i);
      step();
      check("fill_count", 64'(count0), 64'(i));
      check("fill_af",    64'(af0),    64'(i >= 14));
      check("fill_ae",    64'(ae0),    64'(i <= 2));
    end
    check("fill_full", 64'(full0), 64'(1));

    // 17th write rejected
    wdata = W'(99);
    step();
    check("ovf_count", 64'(count0), 64'(16));
    check("ovf_flag",  64'(ovf0),   64'(1));
    w_en = 1'b0;

    // Drain with one-cycle read latency
    for (int i = 1; i <= 16; i++) begin
      r_en = 1'b1;
      step();
      check("drain_rdv",   64'(rd_valid0), 64'(1));
      check("drain_rdata", 64'(rdata0),    64'(i));
    end
    r_en = 1'b0;
    step();
    check("drain_empty", 64'(empty0),    64'(1));
    check("drain_rdv0",  64'(rd_valid0), 64'(0));
    check("drain_hold",  64'(rdata0),    64'(16));
    check("ovf_sticky",  64'(ovf0),      64'(1));

    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("ovf_clr", 64'(ovf0), 64'(0));

    // Underflow on empty
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("unf_flag",  64'(unf0),      64'(1));
    check("unf_count", 64'(count0),    64'(0));
    check("unf_rdv",   64'(rd_valid0), 64'(0));
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("unf_clr", 64'(unf0), 64'(0));

    // Full FIFO with simultaneous write/read
    for (int i = 1; i <= 16; i++) begin
      w_en  = 1'b1;
      wdata = W'(i);
      step();
    end
    check("full2", 64'(full0), 64'(1));
    r_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wdata = W'(100 + i);
      step();
      check("fullrw_count", 64'(count0), 64'(16));
      check("fullrw_rdata", 64'(rdata0), 64'(i + 1));
    end
    w_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check("fullrw_drain", 64'(rdata0), (i < 12) ? 64'(i + 5) : 64'(100 + i - 12));
    end
    r_en = 1'b0;
    step();
    check("fullrw_empty", 64'(empty0), 64'(1));
    check("fullrw_ovf",   64'(ovf0),   64'(0));

    // Wrap-around streaming at count 3
    w_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = W'(200 + i);
      step();
    end
    r_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wdata = W'(203 + k);
      step();
      check("wrap_rdata", 64'(rdata0), 64'(200 + k));
      check("wrap_count", 64'(count0), 64'(3));
      check("wrap_flags", 64'({full0, empty0, af0, ae0}), 64'(0));
    end
    w_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("wrap_tail", 64'(rdata0), 64'(240 + k));
    end
    r_en = 1'b0;
    step();
    check("wrap_empty", 64'(empty0), 64'(1));

    // Empty FIFO with write and read together
    w_en  = 1'b1;
    r_en  = 1'b1;
    wdata = W'(55);
    step();
    idle();
    check("wr_on_empty_count", 64'(count0),    64'(1));
    check("wr_on_empty_unf",   64'(unf0),      64'(1));
    check("wr_on_empty_rdv",   64'(rd_valid0), 64'(0));

    // FWFT: fresh start, single entry
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst2");
    w_en  = 1'b1;
    wdata = W'(32'hA5);
    step();
    w_en = 1'b0;
    check("fwft_rdata", 64'(rdata1),    64'(32'hA5));
    check("fwft_rdv",   64'(rd_valid1), 64'(1));
    check("std_norv",   64'(rd_valid0), 64'(0));
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("fwft_empty",  64'(empty1),    64'(1));
    check("fwft_rdv0",   64'(rd_valid1), 64'(0));

    // Reset mid-burst at count 9
    w_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wdata = W'(300 + i);
      step();
    end
    check("burst_count", 64'(count0), 64'(9));
    r_en = 1'b1;
    step();
    check("burst_rdv", 64'(rd_valid0), 64'(1));
    rst = 1'b1;
    step();
    idle();
    check_reset_state("rst3");
    check("rst3_fwft_empty", 64'(empty1), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
